// File: rtl/fpu_result_writeback.sv
// Purpose: picks the datapath or exception-substituted FP result, classifies it, and buffers it in a 2-entry FIFO.
// Latency: a result pushed at edge N is at the FIFO head in cycle N+1. Sticky flags and the counter update at the same edge.
// Backpressure: in_ready falls when both entries are full. There is no pass-through, so a pop does not free a slot until the next cycle.
module fpu_result_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sel,
  input  logic [DATA_WIDTH-1:0] in_exc_result,
  input  logic [DATA_WIDTH-1:0] in_arith_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [3:0]            out_class,
  input  logic                  flag_clr,
  output logic [3:0]            sticky_flags,
  output logic [CNT_WIDTH-1:0]  exc_count
);

  // FIFO occupancy, pointers and storage
  logic [1:0]            count_q, count_d;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] res_q [2];
  logic [3:0]            cls_q [2];

  // Status state
  logic [3:0]            sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, cnt_base;

  // Incoming result path
  logic [DATA_WIDTH-1:0] sel_res;
  logic [7:0]            exp_f;
  logic [22:0]           mant_f;
  logic [3:0]            sel_cls;
  logic                  push, pop;

  // Handshakes come only from registered occupancy, so there is no ready/valid loop
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result   = res_q[rd_ptr_q];
  assign out_class    = cls_q[rd_ptr_q];
  assign sticky_flags = sticky_q;
  assign exc_count    = cnt_q;

  // Select the result and classify it from the single-precision exponent/mantissa fields
  always_comb begin
    sel_res = in_sel ? in_arith_result : in_exc_result;
    exp_f   = sel_res[30:23];
    mant_f  = sel_res[22:0];
    sel_cls = 4'b0000;
    if (exp_f == 8'hFF) begin
      sel_cls = (mant_f != 23'd0) ? 4'b1000 : 4'b0100;
    end else if (exp_f == 8'h00) begin
      sel_cls = (mant_f == 23'd0) ? 4'b0010 : 4'b0001;
    end
  end

  // Next occupancy, sticky flags and saturating exception count (a same-cycle event survives a clear)
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    sticky_d = (flag_clr ? 4'b0000 : sticky_q) | (push ? sel_cls : 4'b0000);
    cnt_base = flag_clr ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (push && !in_sel && !(&cnt_base)) begin
      cnt_d = cnt_base + CNT_WIDTH'(1);
    end
  end

  // FIFO control and status registers; reset drops all buffered entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      sticky_q <= 4'b0000;
      cnt_q    <= '0;
    end else begin
      count_q  <= count_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // FIFO storage is cleared on reset so the head reads zero when empty after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q[0] <= '0;
      res_q[1] <= '0;
      cls_q[0] <= 4'b0000;
      cls_q[1] <= 4'b0000;
    end else if (push) begin
      res_q[wr_ptr_q] <= sel_res;
      cls_q[wr_ptr_q] <= sel_cls;
    end
  end

endmodule

// File: tb/tb_fpu_result_writeback.sv
module tb_fpu_result_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_sel, out_ready, flag_clr;
  logic [31:0] in_exc_result, in_arith_result;

  // Instance with 2-bit exception counter (all datapath checks use this one)
  logic        in_ready, out_valid;
  logic [31:0] out_result;
  logic [3:0]  out_class, sticky_flags;
  logic [1:0]  exc_count;

  // Default-width instance sharing the same inputs
  logic        in_ready_w, out_valid_w;
  logic [31:0] out_result_w;
  logic [3:0]  out_class_w, sticky_flags_w;
  logic [15:0] exc_count_w;

  int checks = 0;
  int errors = 0;
  logic [35:0] sb [$];

  always #5 clk = ~clk;

  fpu_result_writeback #(.DATA_WIDTH(32), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .in_exc_result(in_exc_result), .in_arith_result(in_arith_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_class(out_class),
    .flag_clr(flag_clr), .sticky_flags(sticky_flags), .exc_count(exc_count)
  );

  fpu_result_writeback dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_sel(in_sel),
    .in_exc_result(in_exc_result), .in_arith_result(in_arith_result),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_result(out_result_w), .out_class(out_class_w),
    .flag_clr(flag_clr), .sticky_flags(sticky_flags_w), .exc_count(exc_count_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare the head entry whenever a pop will happen at the coming edge
  always @(negedge clk) begin
    logic [35:0] e;
    #2;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h/%b expected no entry at %0t", out_result, out_class, $time);
      end else begin
        e = sb.pop_front();
        chk("pop_result", out_result, e[31:0]);
        chk("pop_class", {28'd0, out_class}, {28'd0, e[35:32]});
      end
    end
  end

  // Drive one result (called at a negedge); waits for in_ready, records the expected entry
  task automatic send(input logic sel, input logic [31:0] exc, input logic [31:0] ar,
                      input logic [31:0] exp_res, input logic [3:0] exp_cls);
    bit ok = 0;
    in_valid = 1'b1;
    in_sel = sel;
    in_exc_result = exc;
    in_arith_result = ar;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        sb.push_back({exp_cls, exp_res});
        @(negedge clk);
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    chk("drain_sb_empty", sb.size(), 32'd0);
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic clear_flags();
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sel = 1'b0;
    in_exc_result = '0;
    in_arith_result = '0;
    out_ready = 1'b0;
    flag_clr = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_class", {28'd0, out_class}, 32'd0);
    chk("rst_sticky", {28'd0, sticky_flags}, 32'd0);
    chk("rst_exc_count", {30'd0, exc_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Exception-path +Inf
    send(1'b0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'b0100);
    chk("t1_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_sticky", {28'd0, sticky_flags}, 32'h4);
    chk("t1_exc_count", {30'd0, exc_count}, 32'd1);
    drain();
    clear_flags();
    chk("clr_sticky", {28'd0, sticky_flags}, 32'h0);
    chk("clr_exc_count", {30'd0, exc_count}, 32'd0);

    // Arithmetic path, back-to-back: normal, denormal, NaN
    send(1'b1, 32'h7F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000);
    send(1'b1, 32'h7F80_0000, 32'h0000_0001, 32'h0000_0001, 4'b0001);
    send(1'b1, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 4'b1000);
    chk("t2_sticky", {28'd0, sticky_flags}, 32'h9);
    chk("t2_exc_count", {30'd0, exc_count}, 32'd0);
    drain();

    // Backpressure: two fill the FIFO, third is held while a pop frees a slot
    out_ready = 1'b0;
    send(1'b0, 32'hFF80_0000, 32'h1234_5678, 32'hFF80_0000, 4'b0100);
    send(1'b1, 32'h7FC0_0000, 32'h4049_0FDB, 32'h4049_0FDB, 4'b0000);
    chk("t3_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t3_full_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t3_head_held", out_result, 32'hFF80_0000);
    in_valid = 1'b1;
    in_sel = 1'b1;
    in_exc_result = 32'h0000_0000;
    in_arith_result = 32'h807F_FFFF;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_after_pop_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t3_after_pop_head", out_result, 32'h4049_0FDB);
    sb.push_back({4'b0001, 32'h807F_FFFF});
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_exc_count", {30'd0, exc_count}, 32'd1);
    drain();

    // Clear coincident with a push of -0 on the exception path
    flag_clr = 1'b1;
    send(1'b0, 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'b0010);
    flag_clr = 1'b0;
    chk("t4_sticky", {28'd0, sticky_flags}, 32'h2);
    chk("t4_exc_count", {30'd0, exc_count}, 32'd1);
    chk("t4_exc_count_w", {16'd0, exc_count_w}, 32'd1);
    drain();

    // Counter saturation with the 2-bit counter
    clear_flags();
    send(1'b0, 32'h7F80_0000, 32'h0, 32'h7F80_0000, 4'b0100);
    chk("t5_cnt1", {30'd0, exc_count}, 32'd1);
    send(1'b0, 32'hFF80_0000, 32'h0, 32'hFF80_0000, 4'b0100);
    chk("t5_cnt2", {30'd0, exc_count}, 32'd2);
    send(1'b0, 32'h7FC0_0001, 32'h0, 32'h7FC0_0001, 4'b1000);
    chk("t5_cnt3", {30'd0, exc_count}, 32'd3);
    send(1'b0, 32'h0000_0000, 32'h0, 32'h0000_0000, 4'b0010);
    chk("t5_cnt_sat4", {30'd0, exc_count}, 32'd3);
    send(1'b0, 32'h0040_0000, 32'h0, 32'h0040_0000, 4'b0001);
    chk("t5_cnt_sat5", {30'd0, exc_count}, 32'd3);
    chk("t5_cnt_w", {16'd0, exc_count_w}, 32'd5);
    chk("t5_sticky", {28'd0, sticky_flags}, 32'hF);
    drain();
    clear_flags();
    chk("t5_clr_cnt", {30'd0, exc_count}, 32'd0);
    chk("t5_clr_cnt_w", {16'd0, exc_count_w}, 32'd0);

    // Asynchronous reset with two entries buffered
    out_ready = 1'b0;
    send(1'b0, 32'h7F80_0000, 32'h0, 32'h7F80_0000, 4'b0100);
    send(1'b1, 32'h0, 32'h3F80_0000, 32'h3F80_0000, 4'b0000);
    chk("t6_pre_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_pre_in_ready", {31'd0, in_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_rst_out_result", out_result, 32'd0);
    chk("t6_rst_sticky", {28'd0, sticky_flags}, 32'h0);
    chk("t6_rst_exc_count", {30'd0, exc_count}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(1'b1, 32'h7F80_0000, 32'hC000_0000, 32'hC000_0000, 4'b0000);
    chk("t6_resume_out_valid", {31'd0, out_valid}, 32'd1);
    chk("t6_resume_exc_count", {30'd0, exc_count}, 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
